// File: rtl/seq_dtree_engine.sv
// Sequential decision-tree classifier: one comparator walks a programmable
// node table, one node per clock, with valid/ready on input and output and a
// config write port for loading the table while idle.
module seq_dtree_engine #(
  parameter int N_FEAT    = 6,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 64,
  parameter int CLASS_W   = 2,
  parameter int MAX_DEPTH = 16,
  localparam int NA_W   = $clog2(N_NODES),
  localparam int DEP_W  = $clog2(MAX_DEPTH + 1),
  localparam int FI_W   = $clog2(N_FEAT),
  localparam int SH_W   = $clog2(FEAT_W),
  localparam int NODE_W = 1 + FI_W + SH_W + FEAT_W + 2 * NA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CLASS_W-1:0]       out_class_o,
  output logic [DEP_W-1:0]         out_depth_o,
  output logic                     out_err_o,
  input  logic                     cfg_we_i,
  input  logic [NA_W-1:0]          cfg_addr_i,
  input  logic [NODE_W-1:0]        cfg_wdata_i,
  output logic                     cfg_busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};
  localparam logic [FI_W:0]     NF    = (FI_W+1)'(N_FEAT);
  localparam logic [NA_W:0]     NN    = (NA_W+1)'(N_NODES);
  localparam logic [DEP_W-1:0]  DLAST = DEP_W'(MAX_DEPTH - 1);

  // Field offsets within a node word, LSB upwards.
  localparam int RIGHT_LO = 0;
  localparam int LEFT_LO  = NA_W;
  localparam int THR_LO   = 2 * NA_W;
  localparam int SH_LO    = THR_LO + FEAT_W;
  localparam int FI_LO    = SH_LO + SH_W;

  logic [1:0]               state_q, state_d;
  logic [NA_W-1:0]          node_q, node_d;
  logic [DEP_W-1:0]         depth_q, depth_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic [DEP_W-1:0]         odep_q, odep_d;
  logic                     err_q, err_d;
  logic [NODE_W-1:0]        tbl_q [N_NODES];

  logic [NODE_W-1:0] node_w;
  logic              leaf;
  logic [FI_W-1:0]   fidx;
  logic [SH_W-1:0]   shift;
  logic [FEAT_W-1:0] thr;
  logic [NA_W-1:0]   left, right, child;
  logic [FEAT_W-1:0] feat_sel;
  logic              go_left, bad_fidx, bad_child, tbl_we;

  assign in_ready_o  = (state_q == IDLE) && !cfg_we_i;
  assign cfg_busy_o  = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_class_o = class_q;
  assign out_depth_o = odep_q;
  assign out_err_o   = err_q;
  assign tbl_we      = (state_q == IDLE) && cfg_we_i && ({1'b0, cfg_addr_i} < NN);

  assign node_w = tbl_q[node_q];
  assign leaf   = node_w[NODE_W-1];
  assign fidx   = node_w[FI_LO +: FI_W];
  assign shift  = node_w[SH_LO +: SH_W];
  assign thr    = node_w[THR_LO +: FEAT_W];
  assign left   = node_w[LEFT_LO +: NA_W];
  assign right  = node_w[RIGHT_LO +: NA_W];

  // Decode the current node: select its feature and compare at reduced precision.
  always_comb begin
    feat_sel = '0;
    for (int unsigned f = 0; f < N_FEAT; f++) begin
      if (fidx == FI_W'(f)) feat_sel = feat_q[f*FEAT_W +: FEAT_W];
    end
    go_left   = (feat_sel >> shift) <= (thr >> shift);
    child     = go_left ? left : right;
    bad_fidx  = ({1'b0, fidx} >= NF);
    bad_child = ({1'b0, child} >= NN);
  end

  // Next-state logic: accept in IDLE, one node per cycle in WALK, hold in DONE.
  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    depth_d = depth_q;
    feat_d  = feat_q;
    class_d = class_q;
    odep_d  = odep_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          feat_d  = in_feat_i;
          node_d  = '0;
          depth_d = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (leaf) begin
          class_d = thr[CLASS_W-1:0];
          odep_d  = depth_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (bad_fidx || bad_child || (depth_q == DLAST)) begin
          class_d = '0;
          odep_d  = depth_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          node_d  = child;
          depth_d = depth_q + DEP_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      node_q  <= '0;
      depth_q <= '0;
      feat_q  <= '0;
      class_q <= '0;
      odep_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      depth_q <= depth_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      odep_q  <= odep_d;
      err_q   <= err_d;
    end
  end

  // Node table: all class-0 leaves on reset, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NODES; i++) tbl_q[i] <= LEAF0;
    end else if (tbl_we) begin
      tbl_q[cfg_addr_i] <= cfg_wdata_i;
    end
  end

endmodule

// File: doc/seq_dtree_engine.md
# seq_dtree_engine

Parametrised, sequential decision-tree classifier. Replaces the fixed, hard-wired comparator trees with one comparator plus a programmable node table. The tree is walked one node per clock, with reduced-precision compares selectable per node. Sits between the feature quantiser and the class-output logic, with valid/ready handshakes on both sides and a config write port for loading trees.

## Interface
Parameters:
- N_FEAT, 6: number of input features.
- FEAT_W, 8: bits per feature.
- N_NODES, 64: node-table entries; NA_W = clog2(N_NODES).
- CLASS_W, 2: class label width.
- MAX_DEPTH, 16: walk limit in nodes; DEP_W = clog2(MAX_DEPTH+1).
- Derived widths: FI_W = clog2(N_FEAT), SH_W = clog2(FEAT_W).
- Node word width: NODE_W = 1 + FI_W + SH_W + FEAT_W + 2·NA_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine accepts a vector.
- in_feat  in  N_FEAT·FEAT_W  feature f occupies bits [f·FEAT_W +: FEAT_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  CLASS_W  class label.
- out_depth  out  DEP_W  depth of the terminating node (root = 0).
- out_err  out  1  walk aborted.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  NA_W  node index.
- cfg_wdata  in  NODE_W  node word. Fields from MSB: leaf, fidx, shift, thr, left, right. For a leaf, class = thr[CLASS_W-1:0].
- cfg_busy  out  1  high when the engine is not in IDLE.

## Operation
- Internal decision: an internal node is taken left when (feat[fidx] >> shift) <= (thr >> shift), otherwise right. The compare is unsigned on FEAT_W bits. The shift drops low-order bits, equivalent to comparing only feat[FEAT_W-1:shift].
- Node table: an N_NODES register array, read combinationally. Reset loads every entry as a leaf with class 0.
- FSM states: IDLE, WALK, DONE.
- IDLE:
  - in_ready = !cfg_we.
  - On in_valid && in_ready, latch in_feat, set node = 0 and depth = 0, then go to WALK.
  - cfg_we writes node[cfg_addr] = cfg_wdata. A write and an acceptance never occur in the same cycle.
- WALK: evaluate the current node each cycle, in this priority order:
  - leaf: out_class = class, out_depth = depth, out_err = 0, go to DONE.
  - fidx >= N_FEAT, or the selected child pointer >= N_NODES: out_err = 1, out_class = 0, out_depth = depth, go to DONE.
  - depth == MAX_DEPTH-1 and the node is not a leaf: out_err = 1, out_class = 0, go to DONE.
  - otherwise node = child, depth = depth + 1.
- DONE:
  - out_valid = 1; out_class, out_depth and out_err are held stable.
  - On out_ready, go to IDLE.
- cfg_we is ignored outside IDLE (cfg_busy = 1). The write is dropped, not queued.
- Latched features are immune to in_feat changes after acceptance.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1 after reset deasserts.
  - out_valid = 0, out_class = 0, out_depth = 0, out_err = 0, cfg_busy = 0.
  - Node table: all entries are class-0 leaves.
- Latency: vector accepted on edge E0, terminating node at depth d → out_valid asserts after edge E(d+1).
- Throughput: with out_ready held high, the next acceptance is at E(d+3), giving a period of d+3 cycles.
- out_valid stays high, with its payload stable, until the cycle in which out_ready is sampled high. Backpressure may stall the engine indefinitely.
- in_ready is 0 throughout WALK and DONE.
- Reset asserted mid-walk aborts immediately. No partial result is emitted and the node table returns to the all-leaf state.
- A cfg write on edge E is visible to a walk accepted on any later edge.

## Test plan
- Post-reset empty table. Apply any vector with out_ready = 1 → out_class = 0, out_depth = 0, out_err = 0, out_valid after 1 edge.
- Three-node tree:
  - node0 = internal, fidx 5, shift 1, thr 13, left 1, right 2. Node1 = leaf class 1, node2 = leaf class 3.
  - X5 = 12 → class 1, depth 1.
  - X5 = 13 → class 1: the values are equal after the shift.
  - X5 = 14 → class 3.
- Chain of internal nodes that is always taken left, with no leaf within MAX_DEPTH = 16 → out_err = 1, out_class = 0, out_depth = 15, out_valid after E16.
- Internal node with fidx = 6 (N_FEAT = 6) → out_err = 1 at depth 0.
- Hold out_ready = 0 for 10 cycles after out_valid rises → payload stable, in_ready = 0. Change in_feat during the walk → result unaffected.
- cfg_we pulsed during WALK → table unchanged (read back through a later classification). cfg_we in IDLE with in_valid = 1 → in_ready = 0 that cycle, write lands, vector accepted the next cycle using the new node.
